// File: rtl/reg_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_bank_pkg                                                         |
// | Constants and request type shared by the register bank and its mux. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package reg_bank_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int NREG       = 4;
  localparam int REG_ADDR_W = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] regNo;
    logic [DEF_WIDTH-1:0]  data;
  } wr_req_t;

  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] regNo);
    reg_onehot = NREG'(1) << regNo;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wr_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wr_fifo                                                              |
// | Synchronous FIFO exposing its storage and per-slot valid flags.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wr_fifo #(
  parameter int DEPTH   = 2,
  parameter int ENTRY_W = 34
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clr_i,
  input  logic                              push_i,
  input  logic                              pop_i,
  input  logic [ENTRY_W-1:0]                din_i,
  output logic [ENTRY_W-1:0]                head_o,
  output logic [$clog2(DEPTH):0]            count_o,
  output logic [DEPTH-1:0][ENTRY_W-1:0]     entries_o,
  output logic [DEPTH-1:0]                  valid_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push_i);
      rd_ptr_d = rd_ptr_q + AW'(pop_i);
      count_d  = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: slots are only observed through valid_o or a pop.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_comb begin
    logic [AW-1:0] offs;
    offs      = '0;
    valid_o   = '0;
    entries_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      offs         = AW'(k) - rd_ptr_q;
      valid_o[k]   = ({1'b0, offs} < count_q);
      entries_o[k] = mem_q[k];
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/reg_bank_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_bank_writer                                                      |
// | Queued write port for the 4-entry register bank with pending flags.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module reg_bank_writer
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wrValid,
  output logic                    wrReady,
  input  logic [REG_ADDR_W-1:0]   wrRegNo,
  input  logic [WIDTH-1:0]        wrData,
  input  logic                    hold,
  input  logic                    clr,
  output logic [WIDTH-1:0]        q0,
  output logic [WIDTH-1:0]        q1,
  output logic [WIDTH-1:0]        q2,
  output logic [WIDTH-1:0]        q3,
  output logic [NREG-1:0]         pending,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = REG_ADDR_W + WIDTH;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] regNo;
    logic [WIDTH-1:0]      data;
  } req_t;

  req_t                          w_push_req;
  req_t                          w_head;
  logic [DEPTH-1:0][ENTRY_W-1:0] w_entries;
  logic [DEPTH-1:0]              w_valid;
  logic                          w_push;
  logic                          w_pop;
  logic [NREG-1:0]               w_we;
  logic [WIDTH-1:0]              bank_q [NREG];
  logic [WIDTH-1:0]              bank_d [NREG];

  assign wrReady    = (count != CW'(DEPTH));
  assign w_push     = wrValid && wrReady && !clr;
  assign w_pop      = (count != '0) && !hold && !clr;
  assign w_push_req = '{regNo: wrRegNo, data: wrData};

  wr_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr),
    .push_i    (w_push),
    .pop_i     (w_pop),
    .din_i     (w_push_req),
    .head_o    (w_head),
    .count_o   (count),
    .entries_o (w_entries),
    .valid_o   (w_valid)
  );

  always_comb begin
    w_we = w_pop ? reg_onehot(w_head.regNo) : '0;
    for (int i = 0; i < NREG; i++) begin
      if (clr)         bank_d[i] = '0;
      else if (w_we[i]) bank_d[i] = w_head.data;
      else             bank_d[i] = bank_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) bank_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) bank_q[i] <= bank_d[i];
    end
  end

  // Derived from registered FIFO slots only, so no input reaches it combinationally.
  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_valid[k]) pending = pending | reg_onehot(w_entries[k][ENTRY_W-1 -: REG_ADDR_W]);
    end
  end

  assign q0 = bank_q[0];
  assign q1 = bank_q[1];
  assign q2 = bank_q[2];
  assign q3 = bank_q[3];

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reg_bank_writer                                                   |
// | Directed and random stimulus against a queue-based bank model.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_reg_bank_writer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrValid = 1'b0;
  logic        wrReady;
  logic [1:0]  wrRegNo = '0;
  logic [31:0] wrData = '0;
  logic        hold = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] q0, q1, q2, q3;
  logic [3:0]  pending;
  logic [1:0]  count;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_q [4];
  bit   [1:0]  m_r [$];
  logic [31:0] m_d [$];

  always #5 clk = ~clk;

  reg_bank_writer #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wrValid(wrValid), .wrReady(wrReady),
    .wrRegNo(wrRegNo), .wrData(wrData), .hold(hold), .clr(clr),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .pending(pending), .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_q[i] = '0;
    m_r.delete();
    m_d.delete();
  endtask

  task automatic check_all();
    logic [3:0] pend;
    pend = '0;
    foreach (m_r[j]) pend[m_r[j]] = 1'b1;
    chk("q0", q0, m_q[0]);
    chk("q1", q1, m_q[1]);
    chk("q2", q2, m_q[2]);
    chk("q3", q3, m_q[3]);
    chk("count", count, m_r.size());
    chk("pending", pending, pend);
    chk("wrReady", wrReady, (m_r.size() != DEPTH));
  endtask

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic step(input bit v, input bit [1:0] r, input logic [31:0] d,
                      input bit h, input bit c, output bit acc);
    bit ready;
    wrValid = v; wrRegNo = r; wrData = d; hold = h; clr = c;
    ready = (m_r.size() != DEPTH);
    @(posedge clk);
    acc = 1'b0;
    if (c) begin
      model_clear();
    end else begin
      if (m_r.size() != 0 && !h) begin
        m_q[m_r[0]] = m_d[0];
        void'(m_r.pop_front());
        void'(m_d.pop_front());
      end
      if (v && ready) begin
        m_r.push_back(r);
        m_d.push_back(d);
        acc = 1'b1;
      end
    end
    #1 check_all();
  endtask

  task automatic do_reset();
    wrValid = 1'b0; hold = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    #2;
    model_clear();
    check_all();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_all();
  endtask

  initial begin
    bit acc;
    int tries;
    model_clear();

    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_all();

    // Single write to register 2
    step(1, 2'd2, 32'hDEADBEEF, 0, 0, acc);
    chk("single_pend", pending, 4'b0100);
    step(0, 2'd0, 32'h0, 0, 0, acc);
    chk("single_q2", q2, 32'hDEADBEEF);
    chk("single_pend_clr", pending, 4'b0000);

    // Back-to-back writes
    for (int i = 0; i < 4; i++) begin
      step(1, 2'(i), 32'(i + 1), 0, 0, acc);
      chk("b2b_ready", wrReady, 1'b1);
    end
    step(0, 2'd0, 32'h0, 0, 0, acc);
    chk("b2b_q3", q3, 32'd4);

    // Fill under hold, then release with the third request held by the source
    step(1, 2'd0, 32'hA0, 1, 0, acc);
    step(1, 2'd1, 32'hA1, 1, 0, acc);
    step(1, 2'd2, 32'hA2, 1, 0, acc);
    chk("full_ready", wrReady, 1'b0);
    chk("full_count", count, 2'd2);
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 6) begin
      tries++;
      step(1, 2'd2, 32'hA2, 0, 0, acc);
    end
    chk("full_accept_cycle", tries, 2);
    for (int i = 0; i < 3; i++) step(0, 2'd0, 32'h0, 0, 0, acc);
    chk("full_q2", q2, 32'hA2);

    // Same-register ordering
    step(1, 2'd3, 32'h11, 0, 0, acc);
    chk("same_pend1", pending[3], 1'b1);
    step(1, 2'd3, 32'h22, 0, 0, acc);
    chk("same_pend2", pending[3], 1'b1);
    chk("same_mid_q3", q3, 32'h11);
    step(0, 2'd0, 32'h0, 0, 0, acc);
    chk("same_final_q3", q3, 32'h22);
    chk("same_pend3", pending[3], 1'b0);

    // Reset with two entries queued
    step(1, 2'd0, 32'hBB, 1, 0, acc);
    step(1, 2'd1, 32'hCC, 1, 0, acc);
    do_reset();
    chk("rst_q0", q0, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 2'd0, 32'h0, 0, 0, acc);
    chk("rst_no_commit_q1", q1, 32'h0);

    // Clear with one entry queued and a request presented
    step(1, 2'd1, 32'h77, 0, 0, acc);
    step(1, 2'd0, 32'h66, 1, 0, acc);
    step(1, 2'd3, 32'h55, 0, 1, acc);
    chk("clr_q1", q1, 32'h0);
    chk("clr_count", count, 2'd0);
    chk("clr_pend", pending, 4'b0000);
    step(0, 2'd0, 32'h0, 0, 0, acc);
    chk("clr_dropped_q3", q3, 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0, acc);
      if (n == 200) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
